// File: rtl/dino_score_pkg.sv
// Shared types and helpers for the dino score counter.
// Latency: none (types, constants and a combinational compare function).
// Backpressure: not applicable.
package dino_score_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Widest score the high-score compare handles; narrower scores are zero-extended.
  localparam int BCD_CMP_DIGITS = 8;

  // True when BCD value a is strictly greater than b, deciding on the most significant
  // differing digit.
  function automatic logic bcd_gt(input logic [4*BCD_CMP_DIGITS-1:0] a,
                                  input logic [4*BCD_CMP_DIGITS-1:0] b);
    logic decided;
    logic gt;
    decided = 1'b0;
    gt      = 1'b0;
    for (int k = BCD_CMP_DIGITS - 1; k >= 0; k--) begin
      if (!decided && (a[4*k +: 4] != b[4*k +: 4])) begin
        decided = 1'b1;
        gt      = (a[4*k +: 4] > b[4*k +: 4]);
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit of the live score; increments on inc_in and wraps 9 -> 0.
// Latency: digit updates on the edge after inc_in; carry_out is combinational.
// Backpressure: none; every inc_in is taken immediately.
module bcd_digit_cell
  import dino_score_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc_in,
  output bcd_digit_t digit_out,
  output logic       carry_out
);

  // The next digit up only moves when this one rolls over.
  assign carry_out = inc_in & (digit_out == BCD_MAX);

  // Digit register: clear beats increment, 9 rolls back to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_out <= '0;
    end else if (clear) begin
      digit_out <= '0;
    end else if (inc_in) begin
      digit_out <= (digit_out == BCD_MAX) ? bcd_digit_t'(0) : digit_out + bcd_digit_t'(1);
    end
  end

endmodule

// File: rtl/dino_score_counter.sv
// Tick-driven BCD score, published to the renderer only on the falling edge of VGA_VS.
// Latency: score_bcd/score_update valid 1 clk after vga_vs falls; live score 1 clk after a point.
// Backpressure: none; ticks are dropped while run=0. Optional high score: define HISCORE_EN.
module dino_score_counter
  import dino_score_pkg::*;
#(
  parameter int DIGITS          = 3,
  parameter int TICKS_PER_POINT = 6,
  parameter int SATURATE        = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                run,
  input  logic                tick,
  input  logic                vga_vs,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic                score_update,
  output logic                overflow,
  output logic [4*DIGITS-1:0] hi_bcd
);

  localparam int PW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_POINT - 1);

  logic [PW-1:0]       prescaler;
  logic [4*DIGITS-1:0] live;
  logic [DIGITS:0]     carry;
  logic                accept;
  logic                point_due;
  logic                all_nines;
  logic                top_hit;
  logic                vs_q;
  logic                vs_fall;

  assign accept    = run & tick & ~clear;
  assign point_due = accept & (prescaler == PRESC_LAST);
  assign vs_fall   = vs_q & ~vga_vs;

  // Detect the top value so saturation can suppress the increment at the chain input.
  always_comb begin
    all_nines = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (live[4*k +: 4] != BCD_MAX) all_nines = 1'b0;
    end
  end

  // In saturating mode the chain never sees the increment at 99..9; in wrap mode the
  // carry out of the top digit marks the wrap.
  assign carry[0] = point_due & ~(all_nines & (SATURATE != 0));
  assign top_hit  = (SATURATE != 0) ? (point_due & all_nines) : carry[DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .inc_in    (carry[k]),
      .digit_out (live[4*k +: 4]),
      .carry_out (carry[k+1])
    );
  end

  // Prescaler: counts accepted ticks, restarts on each point or clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (clear) begin
      prescaler <= '0;
    end else if (accept) begin
      prescaler <= point_due ? '0 : prescaler + PW'(1);
    end
  end

  // Sticky overflow, only dropped by clear or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (top_hit) begin
      overflow <= 1'b1;
    end
  end

  // Vsync edge detect and shadow load: the pre-increment live value goes out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q         <= 1'b0;
      score_bcd    <= '0;
      score_update <= 1'b0;
    end else begin
      vs_q         <= vga_vs;
      score_update <= vs_fall;
      if (vs_fall) score_bcd <= live;
    end
  end

`ifdef HISCORE_EN
  logic [4*DIGITS-1:0] hi;

  // High score captured when a game is cleared; never lowered except by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
    end else if (clear && bcd_gt(32'(live), 32'(hi))) begin
      hi <= live;
    end
  end

  // High score shadow, republished alongside score_bcd.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_bcd <= '0;
    end else if (vs_fall) begin
      hi_bcd <= hi;
    end
  end
`else
  assign hi_bcd = '0;
`endif

endmodule

// File: tb/tb_dino_score_counter.sv
// Randomized scoreboard bench for dino_score_counter (two parameter sets).
module tb_dino_score_counter;

  logic        clk = 1'b0;
  logic        reset, clear, run, tick, vga_vs;
  logic [11:0] s0, h0;
  logic        up0, ov0;
  logic [7:0]  s1, h1;
  logic        up1, ov1;

  always #10 clk = ~clk;

  dino_score_counter u0 (
    .clk(clk), .reset(reset), .clear(clear), .run(run), .tick(tick), .vga_vs(vga_vs),
    .score_bcd(s0), .score_update(up0), .overflow(ov0), .hi_bcd(h0)
  );

  dino_score_counter #(.DIGITS(2), .TICKS_PER_POINT(1), .SATURATE(0)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .run(run), .tick(tick), .vga_vs(vga_vs),
    .score_bcd(s1), .score_update(up1), .overflow(ov1), .hi_bcd(h1)
  );

  typedef struct {
    logic [11:0] s;
    logic [11:0] h;
  } pub_t;

  pub_t q0[$];
  pub_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_upd   = 0;

  // Reference model state: plain integer scores per instance.
  int live_m[2];
  int presc_m[2];
  int hi_m[2];
  bit ovf_m[2];
  bit vs_prev;
  int vs_ctr = 20;

  function automatic int tpp(input int i);
    return (i == 0) ? 6 : 1;
  endfunction

  function automatic int topv(input int i);
    return (i == 0) ? 999 : 99;
  endfunction

  function automatic bit sat(input int i);
    return (i == 0);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int          x;
    r = '0;
    x = v;
    for (int k = 0; k < 3; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluates the same inputs the DUT sees at each rising edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        live_m[i] = 0; presc_m[i] = 0; hi_m[i] = 0; ovf_m[i] = 0;
      end
      vs_prev = 1'b0;
      q0.delete();
      q1.delete();
    end else begin
      if (vs_prev && !vga_vs) begin
        q0.push_back('{s: to_bcd(live_m[0]), h: to_bcd(hi_m[0])});
        q1.push_back('{s: to_bcd(live_m[1]), h: to_bcd(hi_m[1])});
      end
      vs_prev = vga_vs;
      for (int i = 0; i < 2; i++) begin
        if (clear) begin
`ifdef HISCORE_EN
          if (live_m[i] > hi_m[i]) hi_m[i] = live_m[i];
`endif
          live_m[i] = 0; presc_m[i] = 0; ovf_m[i] = 0;
        end else if (run && tick) begin
          if (presc_m[i] == tpp(i) - 1) begin
            presc_m[i] = 0;
            if (live_m[i] == topv(i)) begin
              ovf_m[i]  = 1'b1;
              live_m[i] = sat(i) ? topv(i) : 0;
            end else begin
              live_m[i]++;
            end
          end else begin
            presc_m[i]++;
          end
        end
      end
    end
  end

  // Monitor: pops an expectation whenever a DUT presents an update.
  always @(negedge clk) begin
    pub_t e;
    if (!reset) begin
      check("u0 update pulse", 32'(up0), 32'(q0.size() != 0));
      if (up0 && q0.size() != 0) begin
        e = q0.pop_front();
        check("u0 score_bcd", 32'(s0), 32'(e.s));
        check("u0 hi_bcd", 32'(h0), 32'(e.h));
        n_upd++;
      end
      check("u1 update pulse", 32'(up1), 32'(q1.size() != 0));
      if (up1 && q1.size() != 0) begin
        e = q1.pop_front();
        check("u1 score_bcd", 32'(s1), 32'(e.s));
        check("u1 hi_bcd", 32'(h1), 32'(e.h));
      end
      check("u0 overflow", 32'(ov0), 32'(ovf_m[0]));
      check("u1 overflow", 32'(ov1), 32'(ovf_m[1]));
    end
  end

  task automatic cyc(input bit t, input bit r, input bit c, input bit v);
    @(posedge clk);
    #1;
    tick = t; run = r; clear = c; vga_vs = v;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " u0 score_bcd"}, 32'(s0), 32'd0);
    check({tag, " u0 update"},    32'(up0), 32'd0);
    check({tag, " u0 overflow"},  32'(ov0), 32'd0);
    check({tag, " u0 hi_bcd"},    32'(h0), 32'd0);
    check({tag, " u1 score_bcd"}, 32'(s1), 32'd0);
    check({tag, " u1 overflow"},  32'(ov1), 32'd0);
    check({tag, " u1 hi_bcd"},    32'(h1), 32'd0);
  endtask

  task automatic rand_phase(input int n, input int tick_pct, input int clear_per);
    bit t, r, c, v;
    for (int k = 0; k < n; k++) begin
      vs_ctr--;
      if (vs_ctr <= 0) vs_ctr = 30 + int'($urandom_range(0, 25));
      v = (vs_ctr > 3);
      t = ($urandom_range(0, 99) < tick_pct);
      r = ($urandom_range(0, 99) < 97);
      c = (clear_per > 0) && ($urandom_range(0, clear_per - 1) == 0);
      cyc(t, r, c, v);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; run = 1'b0; tick = 1'b0; vga_vs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // Twelve ticks at six per point give 002, seen after the next vsync fall.
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("first publish score", 32'(s0), 32'h002);
    check("first publish pulse", 32'(up0), 32'd1);
    vga_vs = 1'b1;
    @(posedge clk);
    #1;
    check("pulse is one cycle", 32'(up0), 32'd0);

    // Dense ticks without clear: u0 saturates at 999, u1 wraps repeatedly.
    rand_phase(9000, 95, 0);
    check("u0 saturated score", 32'(s0), 32'h999);
    // Mixed activity with occasional clears.
    rand_phase(3000, 60, 300);

    // Reset in the middle of a frame clears every output at once.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #2;
    check_zero("mid-frame reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    rand_phase(3000, 70, 400);
    repeat (60) cyc(1'b0, 1'b1, 1'b0, 1'b1);

    check("u0 pending updates", 32'(q0.size()), 32'd0);
    check("u1 pending updates", 32'(q1.size()), 32'd0);
    check("updates observed", 32'(n_upd > 50), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
